// File: rtl/writeback_cycle_pkg.sv
// Shared pipeline constants for the writeback stage: result-select
// encodings, load size/sign codes and error causes.
package writeback_cycle_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] FUNCT_LB  = 3'b000;
    localparam logic [2:0] FUNCT_LH  = 3'b001;
    localparam logic [2:0] FUNCT_LW  = 3'b010;
    localparam logic [2:0] FUNCT_LBU = 3'b100;
    localparam logic [2:0] FUNCT_LHU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_MISALIGN  = 2'b01,
        ERR_RES_SRC   = 2'b10,
        ERR_FUNCT     = 2'b11
    } err_code_e;

endpackage

// File: rtl/writeback_cycle_load_align.sv
// Combinational load extraction and sign/zero extension, with
// misalignment and reserved-size detection.
module load_align
    import writeback_cycle_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct,
    output logic [31:0] o_data,
    output logic        o_misaligned,
    output logic        o_reserved
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            default: w_byte = i_data[31:24];
        endcase
        w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_data       = '0;
        o_misaligned = 1'b0;
        o_reserved   = 1'b0;
        case (i_funct)
            FUNCT_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            FUNCT_LBU: o_data = {24'h0, w_byte};
            FUNCT_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_off[0];
            end
            FUNCT_LHU: begin
                o_data       = {16'h0, w_half};
                o_misaligned = i_off[0];
            end
            FUNCT_LW: begin
                o_data       = i_data;
                o_misaligned = (i_off != 2'b00);
            end
            default:   o_reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_cycle.sv
// Writeback stage: selects the instruction result, registers the
// register-file write, counts retired instructions and tracks errors.
module writeback_cycle
    import writeback_cycle_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidW,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [2:0]       FunctW,
    input  logic [4:0]       RD_W,
    input  logic [31:0]      ALU_ResultW,
    input  logic [31:0]      ReadDataW,
    input  logic [31:0]      PCPlus4W,
    input  logic             instret_clr,
    input  logic             err_clr,
    output logic             RegWriteEnW,
    output logic [4:0]       RD_out,
    output logic [31:0]      ResultW,
    output logic [CNT_W-1:0] instret,
    output logic             wb_error,
    output logic [1:0]       err_code
);

    logic [31:0]      w_load_data;
    logic             w_misaligned;
    logic             w_bad_funct;
    logic [31:0]      w_result;
    logic             w_err;
    err_code_e        w_err_code;

    logic             r_we;
    logic [4:0]       r_rd;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_instret;
    logic             r_wb_error;
    err_code_e        r_err_code;

    load_align u_load_align (
        .i_data       (ReadDataW),
        .i_off        (ALU_ResultW[1:0]),
        .i_funct      (FunctW),
        .o_data       (w_load_data),
        .o_misaligned (w_misaligned),
        .o_reserved   (w_bad_funct)
    );

    // Load-size checks only matter when the load path is actually selected.
    always_comb begin
        w_result   = '0;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        case (ResultSrcW)
            RES_ALU: w_result = ALU_ResultW;
            RES_PC4: w_result = PCPlus4W;
            RES_LOAD: begin
                if (w_bad_funct) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_FUNCT;
                end else if (w_misaligned) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_MISALIGN;
                end else begin
                    w_result = w_load_data;
                end
            end
            default: begin
                w_err      = 1'b1;
                w_err_code = ERR_RES_SRC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_result   <= '0;
            r_instret  <= '0;
            r_wb_error <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_we <= 1'b0;
            if (ValidW) begin
                r_rd     <= RD_W;
                r_result <= w_err ? 32'h0 : w_result;
                r_we     <= RegWriteW && (RD_W != 5'd0) && !w_err;
            end

            if (instret_clr)
                r_instret <= '0;
            else if (ValidW)
                r_instret <= r_instret + CNT_W'(1);

            // A new error outranks a clear arriving in the same cycle.
            if (ValidW && w_err) begin
                r_wb_error <= 1'b1;
                r_err_code <= w_err_code;
            end else if (err_clr) begin
                r_wb_error <= 1'b0;
            end
        end
    end

    assign RegWriteEnW = r_we;
    assign RD_out      = r_rd;
    assign ResultW     = r_result;
    assign instret     = r_instret;
    assign wb_error    = r_wb_error;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_writeback_cycle.sv
// Directed self-checking bench for writeback_cycle (64-bit counter
// instance plus an 8-bit counter instance for the wrap case).
module tb_writeback_cycle;
    import writeback_cycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidW, RegWriteW, instret_clr, err_clr;
    logic [1:0]  ResultSrcW;
    logic [2:0]  FunctW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

    logic        RegWriteEnW, wb_error;
    logic [4:0]  RD_out;
    logic [31:0] ResultW;
    logic [63:0] instret;
    logic [1:0]  err_code;

    logic        we8, err8;
    logic [4:0]  rd8;
    logic [31:0] res8;
    logic [7:0]  instret8;
    logic [1:0]  code8;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [63:0] cnt_before;

    always #5 clk = ~clk;

    writeback_cycle dut (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .FunctW(FunctW), .RD_W(RD_W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .instret_clr(instret_clr), .err_clr(err_clr),
        .RegWriteEnW(RegWriteEnW), .RD_out(RD_out), .ResultW(ResultW),
        .instret(instret), .wb_error(wb_error), .err_code(err_code)
    );

    writeback_cycle #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .FunctW(FunctW), .RD_W(RD_W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .instret_clr(instret_clr), .err_clr(err_clr),
        .RegWriteEnW(we8), .RD_out(rd8), .ResultW(res8),
        .instret(instret8), .wb_error(err8), .err_code(code8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] src, input logic [2:0] fn, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                         input logic rw);
        ResultSrcW = src; FunctW = fn; RD_W = rd; ALU_ResultW = alu;
        ReadDataW = rdata; PCPlus4W = pc4; RegWriteW = rw; ValidW = 1'b1;
        step();
        ValidW = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ValidW = 1'b1; RegWriteW = 1'b1; ResultSrcW = RES_ALU; FunctW = 3'b000;
        RD_W = 5'd3; ALU_ResultW = 32'h55; ReadDataW = '0; PCPlus4W = '0;
        instret_clr = 1'b0; err_clr = 1'b0;
        step(); step();
        tests_run++; if (RegWriteEnW !== 1'b0) begin tests_failed++; $display("FAIL rst_we: got %0b want 0", RegWriteEnW); end
        tests_run++; if (RD_out !== 5'd0) begin tests_failed++; $display("FAIL rst_rd: got %0d want 0", RD_out); end
        tests_run++; if (ResultW !== 32'h0) begin tests_failed++; $display("FAIL rst_result: got %h want 0", ResultW); end
        tests_run++; if (instret !== 64'd0) begin tests_failed++; $display("FAIL rst_instret: got %0d want 0", instret); end
        tests_run++; if (wb_error !== 1'b0 || err_code !== 2'b00) begin tests_failed++; $display("FAIL rst_err: got %0b/%0b want 0/00", wb_error, err_code); end
        rst = 1'b0;
        step();
        ValidW = 1'b0;
        tests_run++; if (instret !== 64'd1) begin tests_failed++; $display("FAIL first_valid_cnt: got %0d want 1", instret); end
        tests_run++; if (RegWriteEnW !== 1'b1 || RD_out !== 5'd3 || ResultW !== 32'h55) begin tests_failed++; $display("FAIL first_valid_out: got %0b/%0d/%h want 1/3/00000055", RegWriteEnW, RD_out, ResultW); end
    endtask

    task automatic test_load_byte();
        issue(RES_LOAD, FUNCT_LB, 5'd5, 32'h3, 32'h80FF_1234, 32'h0, 1'b1);
        tests_run++; if (RegWriteEnW !== 1'b1 || RD_out !== 5'd5) begin tests_failed++; $display("FAIL lb_we_rd: got %0b/%0d want 1/5", RegWriteEnW, RD_out); end
        tests_run++; if (ResultW !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_result: got %h want ffffff80", ResultW); end
        step();
        tests_run++; if (RegWriteEnW !== 1'b0) begin tests_failed++; $display("FAIL we_pulse: got %0b want 0", RegWriteEnW); end
        issue(RES_LOAD, FUNCT_LBU, 5'd6, 32'h1, 32'h80FF_1234, 32'h0, 1'b1);
        tests_run++; if (ResultW !== 32'h0000_0012) begin tests_failed++; $display("FAIL lbu_result: got %h want 00000012", ResultW); end
        issue(RES_LOAD, FUNCT_LH, 5'd6, 32'h0, 32'h1234_8001, 32'h0, 1'b1);
        tests_run++; if (ResultW !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL lh_result: got %h want ffff8001", ResultW); end
    endtask

    task automatic test_load_half();
        issue(RES_LOAD, FUNCT_LHU, 5'd8, 32'h2, 32'hBEEF_0001, 32'h0, 1'b1);
        tests_run++; if (ResultW !== 32'h0000_BEEF || RegWriteEnW !== 1'b1) begin tests_failed++; $display("FAIL lhu_result: got %h/%0b want 0000beef/1", ResultW, RegWriteEnW); end
        issue(RES_LOAD, FUNCT_LW, 5'd9, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b1);
        tests_run++; if (ResultW !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL lw_result: got %h want cafef00d", ResultW); end
        cnt_before = instret;
        issue(RES_LOAD, FUNCT_LW, 5'd9, 32'h2, 32'hBEEF_0001, 32'h0, 1'b1);
        tests_run++; if (RegWriteEnW !== 1'b0 || ResultW !== 32'h0) begin tests_failed++; $display("FAIL lw_misalign_out: got %0b/%h want 0/00000000", RegWriteEnW, ResultW); end
        tests_run++; if (wb_error !== 1'b1 || err_code !== 2'b01) begin tests_failed++; $display("FAIL lw_misalign_err: got %0b/%b want 1/01", wb_error, err_code); end
        tests_run++; if (instret !== cnt_before + 64'd1) begin tests_failed++; $display("FAIL err_counted: got %0d want %0d", instret, cnt_before + 64'd1); end
    endtask

    task automatic test_reserved();
        issue(2'b11, FUNCT_LW, 5'd4, 32'h10, 32'h0, 32'h0, 1'b1);
        tests_run++; if (err_code !== 2'b10 || RegWriteEnW !== 1'b0) begin tests_failed++; $display("FAIL res_src: got %b/%0b want 10/0", err_code, RegWriteEnW); end
        issue(RES_LOAD, 3'b011, 5'd4, 32'h0, 32'h1111_2222, 32'h0, 1'b1);
        tests_run++; if (err_code !== 2'b11 || ResultW !== 32'h0) begin tests_failed++; $display("FAIL res_funct: got %b/%h want 11/00000000", err_code, ResultW); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        tests_run++; if (wb_error !== 1'b0) begin tests_failed++; $display("FAIL err_clr: got %0b want 0", wb_error); end
        issue(RES_ALU, 3'b011, 5'd4, 32'h0000_0123, 32'h0, 32'h0, 1'b1);
        tests_run++; if (wb_error !== 1'b0 || ResultW !== 32'h0000_0123 || RegWriteEnW !== 1'b1) begin tests_failed++; $display("FAIL alu_ignores_funct: got %0b/%h/%0b want 0/00000123/1", wb_error, ResultW, RegWriteEnW); end
    endtask

    task automatic test_pcplus4();
        cnt_before = instret;
        issue(RES_PC4, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0000_0104, 1'b1);
        tests_run++; if (RegWriteEnW !== 1'b0) begin tests_failed++; $display("FAIL pc4_rd0_we: got %0b want 0", RegWriteEnW); end
        tests_run++; if (ResultW !== 32'h0000_0104 || instret !== cnt_before + 64'd1) begin tests_failed++; $display("FAIL pc4_result_cnt: got %h/%0d want 00000104/%0d", ResultW, instret, cnt_before + 64'd1); end
        issue(RES_ALU, 3'b000, 5'd12, 32'hDEAD_0000, 32'h0, 32'h0, 1'b0);
        tests_run++; if (RegWriteEnW !== 1'b0) begin tests_failed++; $display("FAIL regwrite0_we: got %0b want 0", RegWriteEnW); end
        issue(RES_PC4, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0000_0104, 1'b1);
    endtask

    task automatic test_idle();
        cnt_before = instret;
        RegWriteW = 1'b1; RD_W = 5'd7; ResultSrcW = RES_ALU; ALU_ResultW = 32'h77; ValidW = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++; if (RegWriteEnW !== 1'b0 || RD_out !== 5'd0 || ResultW !== 32'h0000_0104 || instret !== cnt_before) begin
                tests_failed++; $display("FAIL idle_%0d: got we=%0b rd=%0d res=%h cnt=%0d want 0/0/00000104/%0d", i, RegWriteEnW, RD_out, ResultW, instret, cnt_before);
            end
        end
    endtask

    task automatic test_err_collision();
        issue(RES_LOAD, FUNCT_LH, 5'd3, 32'h1, 32'h0, 32'h0, 1'b1);
        tests_run++; if (wb_error !== 1'b1 || err_code !== 2'b01) begin tests_failed++; $display("FAIL lh_misalign: got %0b/%b want 1/01", wb_error, err_code); end
        err_clr = 1'b1;
        issue(2'b11, 3'b000, 5'd3, 32'h0, 32'h0, 32'h0, 1'b1);
        err_clr = 1'b0;
        tests_run++; if (wb_error !== 1'b1 || err_code !== 2'b10) begin tests_failed++; $display("FAIL set_beats_clr: got %0b/%b want 1/10", wb_error, err_code); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        instret_clr = 1'b1; step(); instret_clr = 1'b0;
        tests_run++; if (instret !== 64'd0 || instret8 !== 8'd0) begin tests_failed++; $display("FAIL clr: got %0d/%0d want 0/0", instret, instret8); end
        ResultSrcW = RES_ALU; RegWriteW = 1'b1; RD_W = 5'd10; ValidW = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            ALU_ResultW = 32'(i) * 32'h0101;
            step();
            tests_run++; if (ResultW !== 32'(i) * 32'h0101 || RegWriteEnW !== 1'b1) begin
                tests_failed++; $display("FAIL b2b_%0d: got %h/%0b want %h/1", i, ResultW, RegWriteEnW, 32'(i) * 32'h0101);
            end
        end
        tests_run++; if (instret8 !== 8'hFF || instret !== 64'd255) begin tests_failed++; $display("FAIL cnt_allones: got %h/%0d want ff/255", instret8, instret); end
        step();
        tests_run++; if (instret8 !== 8'h00 || instret !== 64'd256) begin tests_failed++; $display("FAIL cnt_wrap: got %h/%0d want 00/256", instret8, instret); end
        instret_clr = 1'b1; step(); instret_clr = 1'b0; ValidW = 1'b0;
        tests_run++; if (instret !== 64'd0 || instret8 !== 8'd0) begin tests_failed++; $display("FAIL clr_wins: got %0d/%0d want 0/0", instret, instret8); end
    endtask

    task automatic test_reset_midstream();
        issue(RES_ALU, 3'b000, 5'd9, 32'h0000_ABCD, 32'h0, 32'h0, 1'b1);
        issue(2'b11, 3'b000, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1);
        tests_run++; if (instret !== 64'd2 || wb_error !== 1'b1) begin tests_failed++; $display("FAIL pre_rst: got %0d/%0b want 2/1", instret, wb_error); end
        RD_W = 5'd9; ALU_ResultW = 32'h1; ResultSrcW = RES_ALU; RegWriteW = 1'b1;
        ValidW = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; ValidW = 1'b0;
        tests_run++; if (RegWriteEnW !== 1'b0 || RD_out !== 5'd0 || ResultW !== 32'h0 || instret !== 64'd0 || wb_error !== 1'b0 || err_code !== 2'b00) begin
            tests_failed++; $display("FAIL mid_rst: got we=%0b rd=%0d res=%h cnt=%0d err=%0b code=%b want all 0", RegWriteEnW, RD_out, ResultW, instret, wb_error, err_code);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_reserved();
        test_pcplus4();
        test_idle();
        test_err_collision();
        test_back_to_back_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/writeback_cycle.md
WRITEBACK_CYCLE -- requirements
Module: writeback_cycle

Interface
REQ-001 Parameter CNT_W, default 64, width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ValidW  input  1  one-cycle pulse per new instruction presented by the memory stage; held inputs without ValidW are ignored.
REQ-005 RegWriteW  input  1  instruction writes a register.
REQ-006 ResultSrcW  input  2  result select: 00 ALU, 01 load data, 10 PCPlus4, 11 reserved.
REQ-007 FunctW  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others reserved.
REQ-008 RD_W  input  5  destination register.
REQ-009 ALU_ResultW, ReadDataW, PCPlus4W  input  32 each  candidate results; ALU_ResultW[1:0] is the load byte offset.
REQ-010 instret_clr, err_clr  input  1 each  synchronous clear of counter / sticky error.
REQ-011 RegWriteEnW  output  1  register-file write enable, registered.
REQ-012 RD_out  output  5  register-file write address, registered.
REQ-013 ResultW  output  32  register-file write data and forwarding value, registered.
REQ-014 instret  output  CNT_W  retired-instruction count.
REQ-015 wb_error  output  1  sticky error flag.
REQ-016 err_code  output  2  cause of most recent error: 01 misaligned load, 10 reserved ResultSrc, 11 reserved FunctW.

Function
REQ-017 Latency is exactly one cycle: outputs reflect the instruction whose ValidW was high on the previous edge.
REQ-018 Result mux: 00 -> ALU_ResultW; 01 -> formatted load data; 10 -> PCPlus4W.
REQ-019 Load formatting: byte = ReadDataW[8*off+7:8*off]; half = ReadDataW[16*off[1]+15:16*off[1]]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes ReadDataW.
REQ-020 Misaligned: LH/LHU with off[0]=1, or LW with off!=00 -> error code 01.
REQ-021 RegWriteEnW rises only when ValidW=1, RegWriteW=1, RD_W!=0, and there is no error; otherwise it is 0 for that cycle.
REQ-022 An erroring instruction yields ResultW=0, RegWriteEnW=0, sets wb_error, and loads err_code; error is still counted as retired.
REQ-023 Cycles without ValidW: RegWriteEnW=0; RD_out and ResultW hold previous values.
REQ-024 instret increments by 1 per ValidW; wraps from all-ones to 0 without flag.
REQ-025 instret_clr with ValidW in same cycle: clear wins, instret=0 next cycle.
REQ-026 err_clr with new error in same cycle: set wins, wb_error=1 and err_code updated.
REQ-027 FunctW and the load formatting are evaluated only when ResultSrcW=01.

Reset
REQ-028 On rst=1 at a clock edge: RegWriteEnW=0, RD_out=0, ResultW=0, instret=0, wb_error=0, err_code=00.
REQ-029 rst takes priority over ValidW, instret_clr and err_clr; an instruction presented during reset is dropped and not counted.
REQ-030 The first ValidW accepted is on the first edge with rst=0.

Structure
REQ-031 The ResultSrc encodings, FunctW load codes and err_code values are defined as constants in the shared pipeline package.
REQ-032 Load extraction and extension form one combinational sub-module, load_align, instantiated once.
REQ-033 All state resides in writeback_cycle: the output register, counter, and sticky error.

Verification
REQ-034 LB, off=3, ReadDataW=0x80FF_1234, RD_W=5, ValidW -> next cycle RegWriteEnW=1, RD_out=5, ResultW=0xFFFF_FF80.
REQ-035 LHU, off=2, ReadDataW=0xBEEF_0001 -> ResultW=0x0000_BEEF; LW, off=2 -> RegWriteEnW=0, ResultW=0, wb_error=1, err_code=01.
REQ-036 ResultSrcW=10, PCPlus4W=0x0000_0104, RD_W=0, RegWriteW=1 -> RegWriteEnW=0, instret incremented.
REQ-037 ValidW held low 5 cycles with inputs static -> RegWriteEnW=0 throughout, instret unchanged.
REQ-038 Preload instret to all-ones (CNT_W=8, value 0xFF) plus ValidW -> 0x00; instret_clr with ValidW -> 0.
REQ-039 Error and err_clr in same cycle -> wb_error=1; rst asserted mid-stream with ValidW=1 -> all outputs 0 and instret 0 next edge.
